seq_frame_ctrl: RTL and testbench
=================================

SEQ_FRAME_CTRL -- requirements
Module: seq_frame_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 256, table depth in 32-bit words (DEPTH/2 frames).
REQ-002 SHALL have port clk_i, input, 1, system clock; the block uses this single clock only.
REQ-003 SHALL have port reset_i, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port gate_i, input, 1, run enable; a rising edge starts playback.
REQ-005 SHALL have port presc_i, input, 32, prescaler in clocks per tick; 0 is treated as 1.
REQ-006 SHALL have port tlen_i, input, 16, table length in frames.
REQ-007 SHALL have port trepeat_i, input, 16, table repeat count; 0 means infinite.
REQ-008 SHALL have port table_rst_i, input, 1, pulse that clears the write pointer and table_err_o.
REQ-009 SHALL have port table_wstb_i, input, 1, write strobe for table_data_i.
REQ-010 SHALL have port table_data_i, input, 32, table word.
REQ-011 SHALL have port out_o, output, 6, outputs of the current frame.
REQ-012 SHALL have port active_o, output, 1, high outside IDLE.
REQ-013 SHALL have port cur_frame_o, output, 16, index of the current frame (0-based).
REQ-014 SHALL have port cur_fcycle_o, output, 16, completed repeats of the current frame.
REQ-015 SHALL have port cur_tcycle_o, output, 16, completed table passes.
REQ-016 SHALL have port state_o, output, 2, state encoding: IDLE=0, FETCH=1, RUN=2.
REQ-017 SHALL have port table_err_o, output, 1, sticky write-error flag.

Function
REQ-018 Frame format SHALL be 2 words: word0[31:16] is the repeat count (0 is treated as 1) and word0[5:0] is the outputs; word1 is the time in ticks (0 is treated as 1).
REQ-019 Each table_wstb_i SHALL store the word at the write pointer and then increment the pointer.
REQ-020 A write SHALL be dropped and table_err_o set when the pointer equals DEPTH or active_o=1.
REQ-021 The effective length SHALL be min(tlen_i, pointer/2).
REQ-022 A gate rising edge (registered previous gate_i=0) in IDLE SHALL enter FETCH; if the effective length is 0 the edge SHALL be ignored and the block SHALL stay in IDLE.
REQ-023 FETCH SHALL read word0 and then word1 (synchronous RAM, 1-cycle read latency) and enter RUN.
REQ-024 out_o SHALL show frame 0 exactly 4 clocks after the clock at which the rising edge is sampled.
REQ-025 RUN SHALL last time*max(presc_i,1) clocks per repeat.
REQ-026 The next frame SHALL be prefetched during RUN so that frame-to-frame and repeat boundaries have no gap.
REQ-027 When a frame's repeats are complete, cur_frame_o SHALL increment and cur_fcycle_o SHALL reset to 0.
REQ-028 After the last frame, cur_frame_o SHALL wrap to 0 and cur_tcycle_o SHALL increment.
REQ-029 When cur_tcycle_o reaches trepeat_i (nonzero), the block SHALL go to IDLE and set out_o to 0.
REQ-030 A prefetch of a single-clock frame SHALL stretch that frame to 3 clocks; this is the only allowed timing deviation.
REQ-031 gate_i=0 in any state SHALL force IDLE on the next clock and set out_o to 0, while the status outputs hold their values.
REQ-032 table_rst_i SHALL abort to IDLE, clear the pointer and table_err_o, and has priority over a simultaneous table_wstb_i.
REQ-033 A new run SHALL zero cur_frame_o, cur_fcycle_o and cur_tcycle_o on entering FETCH.
REQ-034 Counters SHALL be 16-bit saturating; a counter at 65535 SHALL not wrap.
REQ-035 presc_i, tlen_i and trepeat_i SHALL be sampled on every tick; a change takes effect at the next frame boundary.

Reset
REQ-036 reset_i SHALL asynchronously set the state to IDLE.
REQ-037 reset_i SHALL set out_o, active_o, all cur_* outputs, state_o, table_err_o and the write pointer to 0.
REQ-038 Table RAM contents SHALL NOT be cleared by reset_i.
REQ-039 After reset_i is released, a gate_i that is already high SHALL NOT start playback; a fresh rising edge is required.

Verification
REQ-040 Scenario: load 4 words (0x00020005, 3, 0x0001002A, 2), presc=2, tlen=2, trepeat=1, raise gate -> out_o = 5 for 12 clocks, then 0x2A for 4 clocks, then IDLE with out_o=0 and cur_tcycle_o=1.
REQ-041 Scenario: same table with trepeat=0 -> the block still runs after 1000 clocks and cur_tcycle_o increments every 16 clocks.
REQ-042 Scenario: perform 257 writes with DEPTH=256 -> table_err_o=1 and word 255 is intact; then pulse table_rst_i -> table_err_o=0.
REQ-043 Scenario: drop gate_i mid-frame -> state_o=0 and out_o=0 on the next clock; raising gate again restarts at frame 0.
REQ-044 Scenario: tlen=0 or empty table, raise gate -> active_o stays 0.
REQ-045 Scenario: assert reset_i asynchronously mid-RUN -> all outputs are 0 before the next clk_i edge.

Source files
------------

// File: rtl/seq_frame_ctrl.sv
// Table-driven output sequencer: plays 2-word frames {repeat/outputs, ticks} from
// an internal RAM, prefetching the next frame during RUN so boundaries are gapless.
module seq_frame_ctrl #(
   parameter int DEPTH = 256
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        gate_i,
   input  logic [31:0] presc_i,
   input  logic [15:0] tlen_i,
   input  logic [15:0] trepeat_i,
   input  logic        table_rst_i,
   input  logic        table_wstb_i,
   input  logic [31:0] table_data_i,
   output logic [5:0]  out_o,
   output logic        active_o,
   output logic [15:0] cur_frame_o,
   output logic [15:0] cur_fcycle_o,
   output logic [15:0] cur_tcycle_o,
   output logic [1:0]  state_o,
   output logic        table_err_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [1:0] S_IDLE = 2'd0, S_FETCH = 2'd1, S_RUN = 2'd2;

   function automatic logic [15:0] sat16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic [31:0]   r_mem [DEPTH];
   logic [31:0]   r_rdata;
   logic [AW:0]   r_wptr;
   logic          r_err, r_gate_q;
   logic [1:0]    r_state, w_nxt;
   logic [1:0]    r_ph;
   logic [15:0]   r_nrep;
   logic [5:0]    r_nout, r_out;
   logic [31:0]   r_nw1, w_w1;
   logic [15:0]   r_frame, r_fcyc, r_tcyc, r_reps;
   logic [31:0]   r_time, r_presc, r_pcnt, r_tcnt;
   logic [16:0]   w_pairs, w_len;
   logic [15:0]   w_nidx, w_fidx, w_tc_inc;
   logic [AW-1:0] w_raddr;
   logic          w_last_frm, w_last_rep, w_tick, w_rep_end, w_done;
   logic          w_pf_rdy, w_start, w_abort, w_wr_ok, w_load;

   assign w_pairs    = 17'(r_wptr >> 1);
   assign w_len      = ({1'b0, tlen_i} < w_pairs) ? {1'b0, tlen_i} : w_pairs;
   assign w_last_frm = ({1'b0, r_frame} + 17'd1) >= w_len;
   assign w_nidx     = w_last_frm ? 16'd0 : r_frame + 16'd1;
   assign w_fidx     = (r_state == S_FETCH) ? 16'd0 : w_nidx;
   // r_ph walks 0..3: word0 read, word1 read / capture word0, capture word1, ready
   assign w_raddr    = AW'({w_fidx, r_ph[0]});
   assign w_tick     = (r_pcnt == r_presc - 32'd1);
   assign w_rep_end  = w_tick && (r_tcnt == r_time - 32'd1);
   assign w_last_rep = ({1'b0, r_fcyc} + 17'd1) >= {1'b0, r_reps};
   assign w_tc_inc   = sat16(r_tcyc);
   assign w_done     = w_last_frm && (trepeat_i != 16'd0) && (w_tc_inc >= trepeat_i);
   // word1 may be taken straight from the RAM output one clock before it is registered
   assign w_pf_rdy   = r_ph[1];
   assign w_w1       = (r_ph == 2'd2) ? r_rdata : r_nw1;
   assign w_start    = gate_i && !r_gate_q && (w_len != 17'd0);
   assign w_abort    = table_rst_i || !gate_i;
   assign w_wr_ok    = table_wstb_i && !table_rst_i && (r_state == S_IDLE) && (r_wptr != FULL);
   assign w_load     = ((r_state == S_FETCH) && (r_ph == 2'd3)) ||
                       ((r_state == S_RUN) && w_rep_end && w_last_rep && !w_done && w_pf_rdy);

   always_ff @(posedge clk_i) begin
      if (w_wr_ok) r_mem[r_wptr[AW-1:0]] <= table_data_i;
      r_rdata <= r_mem[w_raddr];
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_wptr <= '0;
         r_err  <= 1'b0;
      end else if (table_rst_i) begin
         r_wptr <= '0;
         r_err  <= 1'b0;
      end else if (table_wstb_i) begin
         if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
         else         r_err  <= 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) r_state <= S_IDLE;
      else         r_state <= w_nxt;
   end

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_nxt = S_FETCH;
         S_FETCH: if (r_ph == 2'd3) w_nxt = S_RUN;
         S_RUN:   if (w_rep_end && w_last_rep && w_done) w_nxt = S_IDLE;
         default: w_nxt = S_IDLE;
      endcase
      if (w_abort) w_nxt = S_IDLE;
   end

   always_comb begin
      active_o = (r_state != S_IDLE);
      state_o  = r_state;
   end

   // Reset parks r_gate_q high so a gate already asserted at release is not an edge
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_gate_q <= 1'b1;
         r_out    <= '0;
         r_frame  <= '0;
         r_fcyc   <= '0;
         r_tcyc   <= '0;
         r_ph     <= '0;
         r_nrep   <= '0;
         r_nout   <= '0;
         r_nw1    <= '0;
         r_reps   <= '0;
         r_time   <= '0;
         r_presc  <= '0;
         r_pcnt   <= '0;
         r_tcnt   <= '0;
      end else begin
         r_gate_q <= gate_i;
         if (w_abort) begin
            r_out <= '0;
         end else begin
            if (r_state != S_IDLE) begin
               if (r_ph != 2'd3) r_ph <= r_ph + 2'd1;
               if (r_ph == 2'd1) begin
                  r_nrep <= r_rdata[31:16];
                  r_nout <= r_rdata[5:0];
               end
               if (r_ph == 2'd2) r_nw1 <= r_rdata;
            end
            if ((r_state == S_IDLE) && w_start) begin
               r_frame <= '0;
               r_fcyc  <= '0;
               r_tcyc  <= '0;
               r_ph    <= '0;
            end
            if (r_state == S_RUN) begin
               if (!w_rep_end) begin
                  if (w_tick) begin
                     r_pcnt <= '0;
                     r_tcnt <= r_tcnt + 32'd1;
                  end else begin
                     r_pcnt <= r_pcnt + 32'd1;
                  end
               end else if (!w_last_rep) begin
                  r_fcyc <= sat16(r_fcyc);
                  r_pcnt <= '0;
                  r_tcnt <= '0;
               end else if (w_done) begin
                  r_out   <= '0;
                  r_frame <= '0;
                  r_fcyc  <= '0;
                  r_tcyc  <= w_tc_inc;
               end else if (w_pf_rdy) begin
                  r_frame <= w_nidx;
                  r_fcyc  <= '0;
                  if (w_last_frm) r_tcyc <= w_tc_inc;
               end
            end
            if (w_load) begin
               r_out   <= r_nout;
               r_reps  <= (r_nrep == 16'd0) ? 16'd1 : r_nrep;
               r_time  <= (w_w1 == 32'd0) ? 32'd1 : w_w1;
               r_presc <= (presc_i == 32'd0) ? 32'd1 : presc_i;
               r_pcnt  <= '0;
               r_tcnt  <= '0;
               r_ph    <= '0;
            end
         end
      end
   end

   assign out_o        = r_out;
   assign cur_frame_o  = r_frame;
   assign cur_fcycle_o = r_fcyc;
   assign cur_tcycle_o = r_tcyc;
   assign table_err_o  = r_err;
endmodule

// File: tb/tb_seq_frame_ctrl.sv
// Directed and randomized checks of seq_frame_ctrl against a frame-list reference
// model that expands the table into one expected output word per clock.
module tb_seq_frame_ctrl;
   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        reset_i, gate_i, table_rst_i, table_wstb_i;
   logic [31:0] presc_i, table_data_i;
   logic [15:0] tlen_i, trepeat_i;
   logic [5:0]  out_o;
   logic        active_o, table_err_o;
   logic [15:0] cur_frame_o, cur_fcycle_o, cur_tcycle_o;
   logic [1:0]  state_o;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [31:0] tq[$];
   logic [63:0] eq[$];
   logic        m_err = 1'b0;
   logic        m_fin;
   logic [15:0] m_tc;
   logic [63:0] last;

   always #5 clk = ~clk;

   seq_frame_ctrl #(.DEPTH(DEPTH)) dut (
      .clk_i(clk), .reset_i(reset_i), .gate_i(gate_i), .presc_i(presc_i),
      .tlen_i(tlen_i), .trepeat_i(trepeat_i), .table_rst_i(table_rst_i),
      .table_wstb_i(table_wstb_i), .table_data_i(table_data_i), .out_o(out_o),
      .active_o(active_o), .cur_frame_o(cur_frame_o), .cur_fcycle_o(cur_fcycle_o),
      .cur_tcycle_o(cur_tcycle_o), .state_o(state_o), .table_err_o(table_err_o)
   );

   function automatic logic [63:0] pk(input logic [5:0] o, input logic [1:0] s,
                                      input logic [15:0] f, input logic [15:0] fc,
                                      input logic [15:0] tc);
      return {8'd0, o, s, f, fc, tc};
   endfunction

   function logic [63:0] obs();
      return pk(out_o, state_o, cur_frame_o, cur_fcycle_o, cur_tcycle_o);
   endfunction

   function logic [63:0] all_obs();
      return 64'({out_o, active_o, state_o, cur_frame_o, cur_fcycle_o, cur_tcycle_o, table_err_o});
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [31:0] w);
      table_data_i = w;
      table_wstb_i = 1'b1;
      @(negedge clk);
      table_wstb_i = 1'b0;
      if (tq.size() < DEPTH) tq.push_back(w);
      else m_err = 1'b1;
   endtask

   task automatic trst();
      table_rst_i = 1'b1;
      @(negedge clk);
      table_rst_i = 1'b0;
      tq.delete();
      m_err = 1'b0;
   endtask

   // Expand the stored table into the per-clock sequence of {out, state, frame, repeat, pass}
   function automatic void build(input int maxc);
      int          len, tc;
      logic [31:0] w0, w1;
      longint      reps, dur, pr;
      eq.delete();
      m_fin = 1'b0;
      tc = 0;
      len = int'(tlen_i);
      if (len > tq.size() / 2) len = tq.size() / 2;
      pr = (presc_i == 0) ? 1 : longint'(presc_i);
      while (len > 0 && eq.size() < maxc && !m_fin) begin
         for (int f = 0; f < len; f++) begin
            w0 = tq[2*f];
            w1 = tq[2*f+1];
            reps = (w0[31:16] == 0) ? 1 : longint'(w0[31:16]);
            dur = ((w1 == 0) ? 1 : longint'(w1)) * pr;
            for (longint r = 0; r < reps; r++)
               for (longint c = 0; c < dur; c++)
                  if (eq.size() < maxc) eq.push_back(pk(w0[5:0], 2'd2, 16'(f), 16'(r), 16'(tc)));
         end
         tc++;
         if (trepeat_i != 0 && tc == int'(trepeat_i)) m_fin = 1'b1;
      end
      m_tc = 16'(tc);
   endfunction

   task automatic play(input string tag);
      gate_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk({tag, " fetch"}, obs(), pk(6'd0, 2'd1, 16'd0, 16'd0, 16'd0));
      end
      foreach (eq[i]) begin
         @(negedge clk);
         chk(tag, obs(), eq[i]);
      end
      if (m_fin) begin
         @(negedge clk);
         chk({tag, " end"}, obs(), pk(6'd0, 2'd0, 16'd0, 16'd0, m_tc));
      end
   endtask

   initial begin
      int nf, tm, rp;
      reset_i = 1'b1; gate_i = 1'b1; table_rst_i = 1'b0; table_wstb_i = 1'b0;
      table_data_i = '0; presc_i = 32'd2; tlen_i = 16'd2; trepeat_i = 16'd1;
      #12;
      chk("reset state", all_obs(), 64'd0);
      @(negedge clk);
      reset_i = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("gate high at release", 64'(active_o), 64'd0);
      end
      gate_i = 1'b0;
      @(negedge clk);

      // two-frame table, single pass
      trst();
      wr(32'h0002_0005); wr(32'd3); wr(32'h0001_002A); wr(32'd2);
      build(100);
      play("scn single pass");
      gate_i = 1'b0;
      @(negedge clk);

      // endless repeat, then gate drop mid-frame and restart
      trepeat_i = 16'd0;
      build(1000);
      play("scn endless");
      last = eq[eq.size()-1];
      gate_i = 1'b0;
      @(negedge clk);
      chk("gate drop", obs(), {8'd0, 6'd0, 2'd0, last[47:0]});
      build(40);
      play("restart");
      gate_i = 1'b0;
      @(negedge clk);

      // single-clock frame is stretched to 3 clocks by the prefetch
      trst();
      wr(32'h0001_0011); wr(32'd1); wr(32'h0001_0022); wr(32'd5);
      presc_i = 32'd1; tlen_i = 16'd2; trepeat_i = 16'd1;
      eq.delete();
      repeat (3) eq.push_back(pk(6'h11, 2'd2, 16'd0, 16'd0, 16'd0));
      repeat (5) eq.push_back(pk(6'h22, 2'd2, 16'd1, 16'd0, 16'd0));
      m_fin = 1'b1; m_tc = 16'd1;
      play("short frame");
      gate_i = 1'b0;
      @(negedge clk);

      for (int it = 0; it < 6; it++) begin
         trst();
         presc_i = $urandom_range(0, 3);
         nf = $urandom_range(1, 4);
         for (int f = 0; f < nf; f++) begin
            rp = $urandom_range(0, 3);
            tm = $urandom_range(0, 5);
            if ((rp == 0 ? 1 : rp) * (tm == 0 ? 1 : tm) * (presc_i == 0 ? 1 : int'(presc_i)) < 3) tm = 3;
            wr({16'(rp), 10'($urandom), 6'($urandom_range(0, 63))});
            wr(32'(tm));
         end
         if ($urandom_range(0, 1) == 1) wr($urandom);
         tlen_i = 16'($urandom_range(1, nf + 1));
         trepeat_i = 16'($urandom_range(1, 3));
         build(10000);
         play("random table");
         gate_i = 1'b0;
         @(negedge clk);
      end

      // table overflow: word 256 dropped, last frame still intact
      trst();
      for (int i = 0; i < DEPTH; i++)
         wr((i % 2 == 0) ? {16'd1, 10'd0, 6'(i / 2)} : ((i == DEPTH - 1) ? 32'd5 : 32'd3));
      chk("err at full", 64'(table_err_o), 64'(m_err));
      wr(32'hDEAD_BEEF);
      chk("err overflow", 64'(table_err_o), 64'(m_err));
      presc_i = 32'd1; tlen_i = 16'd200; trepeat_i = 16'd1;
      build(1000);
      play("full table");
      gate_i = 1'b0;
      @(negedge clk);
      trst();
      chk("err cleared", 64'(table_err_o), 64'(m_err));

      // empty table and tlen=0 never start
      gate_i = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("empty table", 64'(active_o), 64'd0);
      end
      gate_i = 1'b0;
      @(negedge clk);
      wr(32'h0001_0003); wr(32'd4);
      tlen_i = 16'd0;
      gate_i = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("tlen zero", 64'(active_o), 64'd0);
      end
      gate_i = 1'b0;
      @(negedge clk);

      // write while active, then async reset mid-RUN
      trst();
      wr(32'h0002_0005); wr(32'd3); wr(32'h0001_002A); wr(32'd2);
      presc_i = 32'd2; tlen_i = 16'd2; trepeat_i = 16'd0;
      gate_i = 1'b1;
      repeat (10) @(negedge clk);
      table_data_i = 32'h1234_5678;
      table_wstb_i = 1'b1;
      @(negedge clk);
      table_wstb_i = 1'b0;
      chk("write while active", 64'(table_err_o), 64'd1);
      chk("running before reset", 64'(state_o), 64'd2);
      #1 reset_i = 1'b1;
      #1 chk("async reset", all_obs(), 64'd0);
      @(negedge clk);
      reset_i = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("no start after reset", 64'(active_o), 64'd0);
      end
      gate_i = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
